// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// For reads, mem_rdata is valid in the same cycle that mem_ready is high.
interface lsu_mem_stage_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit: byte/half/word accesses with local trapping of misaligned and illegal requests.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_load_i,
    input  logic            req_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     store_data_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [31:0]     load_data_o,
    output logic            fault_o,
    output logic            bus_error_o,
    lsu_mem_stage_if.master mem
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e      state_q;
    logic        memValid_q;
    logic        memWe_q;
    logic [31:0] memAddr_q;
    logic [3:0]  memBe_q;
    logic [31:0] memWdata_q;
    logic        done_q;
    logic        fault_q;
    logic        busError_q;
    logic [31:0] loadData_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    logic        anyReq;
    logic        legalOp;
    logic        aligned;
    logic        reqOk;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] loadExt;
    logic        timeoutHit;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] waitCnt_q;

    assign timeoutHit = (waitCnt_q == CntLast);
`else
    localparam int unsigned unusedTimeout = TIMEOUT_CYCLES;

    assign timeoutHit = 1'b0;
`endif

    // Request decode: legality, alignment, byte enables and lane-replicated write data
    always_comb begin
        anyReq   = req_load_i | req_store_i;
        legalOp  = 1'b0;
        aligned  = 1'b1;
        reqBe    = 4'b1111;
        reqWdata = store_data_i;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legalOp = 1'b1;
            3'b100, 3'b101:         legalOp = req_load_i;
            default:                legalOp = 1'b0;
        endcase
        case (funct3_i[1:0])
            2'b00: begin
                reqBe    = 4'b0001 << addr_i[1:0];
                reqWdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                aligned  = ~addr_i[0];
                reqBe    = addr_i[1] ? 4'b1100 : 4'b0011;
                reqWdata = {2{store_data_i[15:0]}};
            end
            default: aligned = (addr_i[1:0] == 2'b00);
        endcase
        reqOk = anyReq & ~(req_load_i & req_store_i) & legalOp & aligned;
    end

    always_comb begin
        rdByte  = mem.mem_rdata[{offset_q, 3'b000} +: 8];
        rdHalf  = offset_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        loadExt = '0;
        case (funct3_q)
            3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
            3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
            3'b010:  loadExt = mem.mem_rdata;
            3'b100:  loadExt = {24'd0, rdByte};
            3'b101:  loadExt = {16'd0, rdHalf};
            default: loadExt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            memValid_q <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memBe_q    <= '0;
            memWdata_q <= '0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            busError_q <= 1'b0;
            loadData_q <= '0;
            funct3_q   <= '0;
            offset_q   <= '0;
`ifdef LSU_TIMEOUT_EN
            waitCnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq && reqOk) begin
                        state_q    <= ACCESS;
                        memValid_q <= 1'b1;
                        memWe_q    <= req_store_i;
                        memAddr_q  <= {addr_i[31:2], 2'b00};
                        memBe_q    <= reqBe;
                        memWdata_q <= reqWdata;
                        funct3_q   <= funct3_i;
                        offset_q   <= addr_i[1:0];
`ifdef LSU_TIMEOUT_EN
                        waitCnt_q  <= '0;
`endif
                    end else if (anyReq) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        fault_q    <= 1'b1;
                        loadData_q <= '0;
                    end
                end
                ACCESS: begin
`ifdef LSU_TIMEOUT_EN
                    if (!mem.mem_ready) waitCnt_q <= waitCnt_q + 1'b1;
`endif
                    // A ready arriving on the limit cycle still completes normally
                    if (mem.mem_ready) begin
                        state_q    <= DONE;
                        memValid_q <= 1'b0;
                        done_q     <= 1'b1;
                        loadData_q <= memWe_q ? '0 : loadExt;
                    end else if (timeoutHit) begin
                        state_q    <= DONE;
                        memValid_q <= 1'b0;
                        done_q     <= 1'b1;
                        busError_q <= 1'b1;
                        loadData_q <= '0;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    fault_q    <= 1'b0;
                    busError_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall is combinational in IDLE so the core holds on the request cycle itself
    assign stall_o       = rst_n & ((state_q == IDLE) ? anyReq : (state_q == ACCESS));
    assign done_o        = done_q;
    assign fault_o       = fault_q;
    assign bus_error_o   = busError_q;
    assign load_data_o   = loadData_q;
    assign mem.mem_valid = memValid_q;
    assign mem.mem_we    = memWe_q;
    assign mem.mem_addr  = memAddr_q;
    assign mem.mem_be    = memBe_q;
    assign mem.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed accesses checked against literals and a size/offset model.
// Build with LSU_TIMEOUT_EN defined to exercise the access timeout abort.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        reqLoad;
    logic        reqStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        stall;
    logic        done;
    logic [31:0] loadData;
    logic        fault;
    logic        busError;

    lsu_mem_stage_if memBus ();

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_load_i   (reqLoad),
        .req_store_i  (reqStore),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .store_data_i (storeData),
        .stall_o      (stall),
        .done_o       (done),
        .load_data_o  (loadData),
        .fault_o      (fault),
        .bus_error_o  (busError),
        .mem          (memBus)
    );

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] expAddr, expWdata, expLoad, heldLoad;
    logic [3:0]  expBe;
    logic        expWe, expFault, expBusErr, memAllowed, cmpEn;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: access size in bytes is 2**funct3[1:0]
    function automatic int sizeOf(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = sizeOf(f3);
        return 4'(((1 << sz) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = sizeOf(f3);
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int bits;
        bits = 8 * sizeOf(f3);
        v = longint'(rd >> (8 * a[1:0]));
        v = v % (longint'(1) << bits);
        if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    function automatic logic modelFault(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (ld && (f3 == 3'd4 || f3 == 3'd5));
        if (!(ld || st)) return 1'b0;
        return (ld && st) || !legal || ((int'(a[1:0]) % sizeOf(f3)) != 0);
    endfunction

    // Per-cycle comparison of DUT outputs against the model, sampled after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmpEn) begin
                if (memBus.mem_valid) begin
                    check("cmp_valid_allowed", {31'd0, memAllowed}, 32'd1);
                    check("cmp_addr", memBus.mem_addr, expAddr);
                    check("cmp_be", {28'd0, memBus.mem_be}, {28'd0, expBe});
                    check("cmp_we", {31'd0, memBus.mem_we}, {31'd0, expWe});
                    if (expWe) check("cmp_wdata", memBus.mem_wdata, expWdata);
                end
                if (done) begin
                    check("cmp_fault", {31'd0, fault}, {31'd0, expFault});
                    check("cmp_bus_error", {31'd0, busError}, {31'd0, expBusErr});
                    check("cmp_load_data", loadData, expLoad);
                    heldLoad = expLoad;
                end else begin
                    check("cmp_fault_idle", {31'd0, fault}, 32'd0);
                    check("cmp_bus_error_idle", {31'd0, busError}, 32'd0);
                    check("cmp_load_held", loadData, heldLoad);
                end
            end
        end
    end

    task automatic setModel(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd);
        expAddr    = {a[31:2], 2'b00};
        expBe      = modelBe(f3, a);
        expWe      = st;
        expWdata   = modelWdata(f3, sd);
        expFault   = modelFault(ld, st, f3, a);
        expBusErr  = 1'b0;
        expLoad    = (ld && !st && !expFault) ? modelLoad(f3, a, rd) : 32'd0;
        memAllowed = !expFault;
    endtask

    task automatic applyStimulus(input string name, input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                                 input int waits, input logic [3:0] hBe, input logic [31:0] hWdata,
                                 input logic [31:0] hLoad, input logic hFault);
        int cyc;
        int expLat;
        bit seenDone;
        bit sawValid;
        @(negedge clk);
        reqLoad = ld; reqStore = st; funct3 = f3; addr = a; storeData = sd;
        memBus.mem_rdata = rd;
        memBus.mem_ready = (waits == 0);
        setModel(ld, st, f3, a, sd, rd);
        expLat = hFault ? 1 : waits + 2;
        #1 check({name, "_stall_req"}, {31'd0, stall}, 32'd1);
        cyc = 0; seenDone = 0; sawValid = 0;
        while (!seenDone && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (memBus.mem_valid) begin
                sawValid = 1;
                check({name, "_be"}, {28'd0, memBus.mem_be}, {28'd0, hBe});
                check({name, "_addr"}, memBus.mem_addr, {a[31:2], 2'b00});
                check({name, "_we"}, {31'd0, memBus.mem_we}, {31'd0, st});
                if (st) check({name, "_wdata"}, memBus.mem_wdata, hWdata);
            end
            if (done) begin
                seenDone = 1;
                check({name, "_latency"}, cyc, expLat);
                check({name, "_fault"}, {31'd0, fault}, {31'd0, hFault});
                check({name, "_load"}, loadData, hLoad);
                check({name, "_stall_done"}, {31'd0, stall}, 32'd0);
                check({name, "_valid_done"}, {31'd0, memBus.mem_valid}, 32'd0);
            end else begin
                check({name, "_stall_wait"}, {31'd0, stall}, 32'd1);
                if (!hFault) check({name, "_valid_wait"}, {31'd0, memBus.mem_valid}, 32'd1);
                if (waits > 0 && cyc == waits + 1) memBus.mem_ready = 1'b1;
            end
        end
        if (!seenDone) check({name, "_done_timeout"}, 32'd0, 32'd1);
        check({name, "_mem_touched"}, {31'd0, sawValid}, {31'd0, !hFault});
        memAllowed = 1'b0;
        reqLoad = 1'b0; reqStore = 1'b0;
        memBus.mem_ready = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        check({name, "_stall"}, {31'd0, stall}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_fault"}, {31'd0, fault}, 32'd0);
        check({name, "_bus_error"}, {31'd0, busError}, 32'd0);
        check({name, "_valid"}, {31'd0, memBus.mem_valid}, 32'd0);
        check({name, "_we"}, {31'd0, memBus.mem_we}, 32'd0);
        check({name, "_load"}, loadData, 32'd0);
    endtask

    // Launch a word load that never sees ready, leaving the DUT waiting in the access state
    task automatic startHungLoad(input logic [31:0] a);
        @(negedge clk);
        reqLoad = 1'b1; reqStore = 1'b0; funct3 = 3'b010; addr = a; storeData = '0;
        memBus.mem_ready = 1'b0; memBus.mem_rdata = 32'hFFFF_FFFF;
        setModel(1'b1, 1'b0, 3'b010, a, 32'd0, 32'd0);
    endtask

    task automatic resetMidWait(input string name);
        cmpEn = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check({name, "_valid"}, {31'd0, memBus.mem_valid}, 32'd0);
        check({name, "_stall"}, {31'd0, stall}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        reqLoad = 1'b0;
        rst_n = 1'b1;
        heldLoad = 32'd0;
        memAllowed = 1'b0;
        cmpEn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput({name, "_after"});
        end
    endtask

    initial begin
        rst_n = 1'b0; cmpEn = 1'b0; memAllowed = 1'b0; heldLoad = '0;
        reqLoad = 1'b0; reqStore = 1'b0; funct3 = '0; addr = '0; storeData = '0;
        memBus.mem_ready = 1'b0; memBus.mem_rdata = '0;
        expAddr = '0; expBe = '0; expWe = 1'b0; expWdata = '0; expFault = 1'b0; expBusErr = 1'b0; expLoad = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset");
        check("reset_addr", memBus.mem_addr, 32'd0);
        check("reset_be", {28'd0, memBus.mem_be}, 32'd0);
        check("reset_wdata", memBus.mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmpEn = 1'b1;

        $display("[TB] loads");
        applyStimulus("lw",     1, 0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
        applyStimulus("lb_neg", 1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 0);
        applyStimulus("lbu",    1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 4'b1000, 32'h0, 32'h0000_0080, 0);
        applyStimulus("lhu",    1, 0, 3'b101, 32'h0000_1002, 32'h0, 32'h8011_2233, 0, 4'b1100, 32'h0, 32'h0000_8011, 0);
        applyStimulus("lh_neg", 1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h8011_2233, 0, 4'b1100, 32'h0, 32'hFFFF_8011, 0);
        applyStimulus("lb_pos", 1, 0, 3'b000, 32'h0000_1000, 32'h0, 32'h8011_2233, 0, 4'b0001, 32'h0, 32'h0000_0033, 0);

        $display("[TB] stores");
        applyStimulus("sb", 0, 1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0);
        applyStimulus("sh", 0, 1, 3'b001, 32'h0000_2002, 32'hABCD_1234, 32'h0, 0, 4'b1100, 32'h1234_1234, 32'h0, 0);
        applyStimulus("sw", 0, 1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 32'hCAFE_F00D, 32'h0, 0);

        $display("[TB] traps");
        applyStimulus("lw_load_first", 1, 0, 3'b010, 32'h0000_1000, 32'h0, 32'h1357_9BDF, 0, 4'b1111, 32'h0, 32'h1357_9BDF, 0);
        applyStimulus("lw_misaligned", 1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h1111_1111, 0, 4'b0000, 32'h0, 32'h0, 1);
        applyStimulus("sh_misaligned", 0, 1, 3'b001, 32'h0000_1001, 32'h0000_BEEF, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
        applyStimulus("load_f3_011",   1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h2222_2222, 0, 4'b0000, 32'h0, 32'h0, 1);
        applyStimulus("store_f3_100",  0, 1, 3'b100, 32'h0000_1000, 32'h5555_5555, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
        applyStimulus("load_and_store", 1, 1, 3'b010, 32'h0000_1000, 32'h0, 32'h3333_3333, 0, 4'b0000, 32'h0, 32'h0, 1);

        $display("[TB] wait states and reset");
        applyStimulus("lw_wait3", 1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'h0BAD_F00D, 3, 4'b1111, 32'h0, 32'h0BAD_F00D, 0);
        startHungLoad(32'h0000_1008);
        repeat (2) @(negedge clk);
        check("rst_pre_valid", {31'd0, memBus.mem_valid}, 32'd1);
        check("rst_pre_stall", {31'd0, stall}, 32'd1);
        resetMidWait("rst_mid_wait");
        applyStimulus("lw_after_rst", 1, 0, 3'b010, 32'h0000_100C, 32'h0, 32'h600D_CAFE, 0, 4'b1111, 32'h0, 32'h600D_CAFE, 0);

        $display("[TB] access timeout");
`ifdef LSU_TIMEOUT_EN
        begin
            int cyc;
            bit seen;
            startHungLoad(32'h0000_3000);
            expBusErr = 1'b1;
            expLoad = 32'd0;
            cyc = 0; seen = 0;
            while (!seen && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    seen = 1;
                    check("to_latency", cyc, 32'd5);
                    check("to_bus_error", {31'd0, busError}, 32'd1);
                    check("to_fault", {31'd0, fault}, 32'd0);
                    check("to_load", loadData, 32'd0);
                    check("to_valid", {31'd0, memBus.mem_valid}, 32'd0);
                    check("to_stall", {31'd0, stall}, 32'd0);
                    reqLoad = 1'b0;
                    memAllowed = 1'b0;
                end else begin
                    check("to_valid_wait", {31'd0, memBus.mem_valid}, 32'd1);
                end
            end
            if (!seen) check("to_done_timeout", 32'd0, 32'd1);
            @(negedge clk);
            checkOutput("to_idle");
        end
`else
        startHungLoad(32'h0000_3000);
        repeat (30) begin
            @(negedge clk);
            check("hang_stall", {31'd0, stall}, 32'd1);
            check("hang_valid", {31'd0, memBus.mem_valid}, 32'd1);
            check("hang_done", {31'd0, done}, 32'd0);
        end
        resetMidWait("hang_reset");
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address and performs byte, halfword and word loads and stores against a data memory over a valid/ready handshake. It stalls the core until the access completes and returns sign- or zero-extended load data for register writeback. Misaligned and illegal requests are trapped locally and never reach memory.

Parameters:
TIMEOUT_CYCLES, 255, maximum ACCESS cycles without mem_ready before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_load  in  1  current instruction is a load
req_store  in  1  current instruction is a store
funct3  in  3  RISC-V size/sign field
addr  in  32  effective address (ALU output)
store_data  in  32  rs2 value
stall  out  1  hold PC/pipeline this cycle
done  out  1  one-cycle pulse: access retired
load_data  out  32  extended load result, valid when done=1
fault  out  1  with done: misaligned, illegal funct3, or load+store both high
bus_error  out  1  with done: timeout abort (0 when LSU_TIMEOUT_EN undefined)
mem_valid  out  1  memory request valid
mem_we  out  1  1 = write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_ready  in  1  memory accepts; for reads mem_rdata is valid in the same cycle
mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE; stall, done, fault, bus_error, mem_valid, mem_we = 0; mem_addr, mem_be, mem_wdata, load_data = 0. Reset during ACCESS drops mem_valid immediately; the access is abandoned.
- States: IDLE, ACCESS, DONE.
- IDLE: stall = req_load|req_store (combinational). On a request:
  - legal and aligned -> register mem_* outputs and go to ACCESS.
  - otherwise -> go to DONE with fault=1; no mem_valid.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - any other funct3 is illegal.
- Aligned: H requires addr[0]=0; W requires addr[1:0]=0.
- mem_be:
  - B: 1<<addr[1:0].
  - H: 4'b0011 or 4'b1100 by addr[1].
  - W: 4'b1111.
  - Loads drive mem_be the same way.
- mem_wdata:
  - SB: byte replicated ×4.
  - SH: halfword ×2.
  - SW: as-is.
- ACCESS: stall=1; mem_valid=1. mem_* held stable until mem_ready=1.
  - On mem_ready: capture the load lane (byte/half selected by addr[1:0]), sign-extend for LB/LH, zero-extend for LBU/LHU; go to DONE.
- DONE: one cycle; done=1, stall=0, mem_valid=0. The core advances this cycle. req_* inputs are ignored in DONE.
  - fault and bus_error are valid only with done; 0 otherwise.
  - load_data is held until the next done. It is 0 for stores and faults.
- Next state after DONE is always IDLE. Back-to-back accesses therefore have one IDLE cycle between them.
- Latency with zero-wait memory: request seen in cycle 0, ACCESS with mem_ready in cycle 1, done in cycle 2. Stall is high in cycles 0–1.
- Inputs (req_*, funct3, addr, store_data) are sampled only in IDLE. The core holds them stable while stall=1.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8+ bit counter clears on entering ACCESS and increments each ACCESS cycle without mem_ready. On reaching TIMEOUT_CYCLES: drop mem_valid, go to DONE with bus_error=1 and load_data=0. A mem_ready arriving in the same cycle as the limit wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; bus_error tied 0.

Test Plan:
1. LW addr=0x1000, mem_ready tied 1, mem_rdata=0xDEADBEEF -> mem_be=1111, mem_addr=0x1000; done in cycle 2 with load_data=0xDEADBEEF; stall high for exactly 2 cycles.
2. LB addr=0x1003, rdata=0x80112233 -> mem_be=1000, load_data=0xFFFFFF80. LBU at same address -> 0x00000080. LHU addr=0x1002 -> 0x00008011.
3. SB addr=0x2001, store_data=0x000000A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5, mem_addr=0x2000. SH addr=0x2002, data=0x1234 -> be=1100, wdata=0x12341234.
4. LW addr=0x1002 and SH addr=0x1001 -> mem_valid never asserted; done+fault in cycle 1. funct3=011 load -> fault. req_load and req_store both high -> fault.
5. LW with mem_ready delayed 3 cycles -> mem_valid and mem_addr stable through waits; done 1 cycle after ready. Assert rst_n=0 mid-wait -> mem_valid and stall 0 immediately, state IDLE, no done.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready=0 -> abort after 4 ACCESS cycles; done+bus_error=1, load_data=0. Without the macro -> stall held indefinitely.
